// File: rtl/volume_ctrl_pkg.sv
// Shared audio types and constants for the volume control path.
package volume_ctrl_pkg;

  localparam int unsigned DATA_BITS = 24;
  localparam int unsigned GAIN_BITS = 8;
  localparam int unsigned GAIN_FRAC = 7;
  localparam int unsigned PROD_BITS = DATA_BITS + GAIN_BITS + 1;

  typedef logic signed [DATA_BITS-1:0] sample_t;
  typedef logic        [GAIN_BITS-1:0] gain_t;

  localparam int unsigned GAIN_UNITY = 1 << GAIN_FRAC;
  localparam gain_t       GAIN_MAX   = '1;

  localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_BITS-1){1'b0}}};

  // Clamp a wide signed value into the signed sample range.
  function automatic sample_t sat_sample(input logic signed [PROD_BITS-1:0] v);
    if (v > PROD_BITS'(SAMPLE_MAX)) begin
      return SAMPLE_MAX;
    end else if (v < PROD_BITS'(SAMPLE_MIN)) begin
      return SAMPLE_MIN;
    end else begin
      return sample_t'(v);
    end
  endfunction

endpackage

// File: rtl/volume_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, debounced level, rise pulse.
module debounce
  import volume_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2**20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_BITS = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic                level_d, level_q;
  logic                level_dly_q;
  logic                press_d, press_q;
  logic [CNT_BITS-1:0] cnt_d, cnt_q;

  // Counter runs while the synced input disagrees with the debounced level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = level_q & ~level_dly_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  // Synchronizer, debounce state and registered rise pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/volume_ctrl.sv
// Volume control: debounced up/down buttons drive a Q1.7 gain that scales the sample stream.
module volume_ctrl
  import volume_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2**20,
  parameter int unsigned GAIN_RESET      = 128,
  parameter int unsigned GAIN_STEP       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 mute,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic [GAIN_BITS-1:0] gain
);

  localparam gain_t STEP = GAIN_BITS'(GAIN_STEP);

  logic up_level, up_press;
  logic down_level, down_press;

  logic mute_s1_q, mute_s2_q;

  gain_t                 gain_d, gain_q;
  logic [GAIN_BITS:0]    gain_sum;

  logic                  s1_valid_d, s1_valid_q;
  logic signed [PROD_BITS-1:0] s1_prod_d, s1_prod_q;
  logic signed [PROD_BITS-1:0] shifted;
  sample_t               sat;

  logic                  out_valid_d, out_valid_q;
  sample_t               out_data_d, out_data_q;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_up),
    .level   (up_level),
    .press   (up_press)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_down),
    .level   (down_level),
    .press   (down_press)
  );

  // Saturating gain step; simultaneous presses cancel.
  always_comb begin
    gain_sum = {1'b0, gain_q} + {1'b0, STEP};
    gain_d   = gain_q;
    if (up_press && !down_press) begin
      gain_d = gain_sum[GAIN_BITS] ? GAIN_MAX : gain_sum[GAIN_BITS-1:0];
    end else if (down_press && !up_press) begin
      gain_d = (gain_q < STEP) ? '0 : (gain_q - STEP);
    end
  end

  // Stage 1: full-precision signed multiply by the zero-extended gain.
  always_comb begin
    s1_valid_d = in_valid;
    s1_prod_d  = s1_prod_q;
    if (in_valid) begin
      s1_prod_d = PROD_BITS'($signed(in_data)) * PROD_BITS'($signed({1'b0, gain_q}));
    end
  end

  // Stage 2: floor shift back to sample scale, saturate, apply mute.
  always_comb begin
    shifted     = s1_prod_q >>> GAIN_FRAC;
    sat         = sat_sample(shifted);
    out_valid_d = s1_valid_q;
    out_data_d  = out_data_q;
    if (s1_valid_q) begin
      out_data_d = mute_s2_q ? '0 : sat;
    end
  end

  // Mute synchronizer, gain register and pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mute_s1_q   <= 1'b0;
      mute_s2_q   <= 1'b0;
      gain_q      <= GAIN_BITS'(GAIN_RESET);
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mute_s1_q   <= mute;
      mute_s2_q   <= mute_s1_q;
      gain_q      <= gain_d;
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign gain      = gain_q;

endmodule

// File: tb/tb_volume_ctrl.sv
// Scoreboard bench for volume_ctrl with a short debounce window.
module tb_volume_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, mute, in_valid;
  logic [23:0] in_data;
  logic        out_valid;
  logic [23:0] out_data;
  logic [7:0]  gain;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  int          model_gain;
  bit          model_mute;

  volume_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .mute      (mute),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gain      (gain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference scaling: floor(x*g/128) clamped to 24-bit signed, zero when muted.
  function automatic logic [23:0] model_out(input logic [23:0] x, input int g, input bit m);
    longint p;
    if (m) return 24'h0;
    p = longint'($signed(x)) * longint'(g);
    p = p >>> 7;
    if (p > 64'sd8388607) p = 64'sd8388607;
    else if (p < -64'sd8388608) p = -64'sd8388608;
    return p[23:0];
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    step(2);
    exp_q.delete();
    rst        = 1'b1;
    model_gain = 128;
  endtask

  task automatic send(input logic [23:0] x);
    in_valid = 1'b1;
    in_data  = x;
    exp_q.push_back(model_out(x, model_gain, model_mute));
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
    step(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(10);
    if (up && !dn) model_gain = (model_gain + 8 > 255) ? 255 : model_gain + 8;
    if (dn && !up) model_gain = (model_gain < 8) ? 0 : model_gain - 8;
    check("gain_press", 32'(gain), 32'(model_gain));
  endtask

  // Output monitor: every strobe must match the oldest expected sample.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    btn_up = 0; btn_down = 0; mute = 0; in_valid = 0; in_data = '0;
    model_mute = 0;
    rst = 1'b1;
    step(1);

    // Reset state
    do_reset();
    check("rst_gain", 32'(gain), 32'd128);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    // Unity gain and two-edge latency
    in_valid = 1'b1;
    in_data  = 24'h123456;
    exp_q.push_back(model_out(24'h123456, model_gain, model_mute));
    step(1);
    in_valid = 1'b0;
    check("lat_edge1", 32'(out_valid), 32'd0);
    step(1);
    check("lat_edge2", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'h123456);
    step(2);
    check("hold_data", 32'(out_data), 32'h123456);

    // Back-to-back samples
    send(24'h000001);
    send(24'hFFFFFF);
    step(4);

    // Held button: exactly one step at edge 8
    btn_up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      check("hold_gain", 32'(gain), (i >= 8) ? 32'd136 : 32'd128);
    end
    btn_up = 1'b0;
    step(12);
    model_gain = 136;
    check("hold_release", 32'(gain), 32'd136);

    // Short glitch: no press
    btn_up = 1'b1;
    step(2);
    btn_up = 1'b0;
    step(20);
    check("glitch", 32'(gain), 32'd136);

    // Both buttons together: no change
    press(1'b1, 1'b1);

    // Lower limit
    do_reset();
    for (int i = 0; i < 17; i++) press(1'b0, 1'b1);
    check("gain_zero", 32'(gain), 32'd0);
    send(24'h400000);
    step(4);

    // Upper limit
    do_reset();
    for (int i = 0; i < 15; i++) press(1'b1, 1'b0);
    check("gain_248", 32'(gain), 32'd248);
    press(1'b1, 1'b0);
    check("gain_255", 32'(gain), 32'd255);
    press(1'b1, 1'b0);
    check("gain_255_hold", 32'(gain), 32'd255);

    // Saturation at max gain
    send(24'h400000);
    send(24'h600000);
    send(24'hA00000);
    send(24'hFFFFFF);
    send(24'h7FFFFF);
    send(24'h800000);
    step(4);

    // Mute: output forced to zero, strobe continues, gain untouched
    mute = 1'b1;
    model_mute = 1;
    step(4);
    send(24'h123456);
    send(24'h400000);
    send(24'hA00000);
    step(4);
    check("mute_gain", 32'(gain), 32'd255);
    mute = 1'b0;
    model_mute = 0;
    step(4);
    send(24'h010000);
    send(24'hFF0000);
    step(4);

    // Reset mid-operation flushes the in-flight sample
    do_reset();
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
    check("gain_200", 32'(gain), 32'd200);
    in_valid = 1'b1;
    in_data  = 24'h111111;
    step(1);
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("flush_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b1;
    model_gain = 128;
    step(3);
    check("flush_valid_after", 32'(out_valid), 32'd0);
    check("flush_gain", 32'(gain), 32'd128);

    send(24'h200000);
    step(4);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/volume_ctrl.md
# volume_ctrl

User-side volume control for the audio path: debounces up/down/mute controls from board buttons and switches, maintains a gain register, and scales the signed 24-bit sample stream by that gain with saturation. It sits between the audio receive datapath and the downstream consumers (output DAC path and level display). It is the input-control counterpart to the LED level display, so the current gain is exported for display.

## Interface
- DATA_BITS, 24, signed sample width
- GAIN_BITS, 8, unsigned gain width; Q1.7 format (128 = unity)
- GAIN_FRAC, 7, fractional bits of gain
- GAIN_RESET, 128, gain after reset (unity)
- GAIN_STEP, 8, gain change per debounced press
- DEBOUNCE_CYCLES, 2**20, stable cycles required to accept a button level change

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- btn_up  in  1  raw volume-up button, asynchronous, active-high
- btn_down  in  1  raw volume-down button, asynchronous, active-high
- mute  in  1  raw mute switch, asynchronous, level, active-high
- in_valid  in  1  sample strobe, one cycle per sample
- in_data  in  DATA_BITS  signed sample
- out_valid  out  1  output sample strobe
- out_data  out  DATA_BITS  scaled signed sample
- gain  out  GAIN_BITS  current gain register

## Operation
- Synchronizers: btn_up, btn_down, mute each pass through a 2-flop synchronizer.
- Debounce (btn_up, btn_down): each has a debounced state and a counter. When synced != debounced, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 on that edge, the debounced state flips and the counter clears. When synced == debounced, the counter clears. A debounced 0->1 transition produces a one-cycle registered press pulse.
- Gain update uses press pulses:
  - Up only: gain = min(gain + GAIN_STEP, 2**GAIN_BITS-1).
  - Down only: gain = max(gain - GAIN_STEP, 0).
  - Both pulses in the same cycle: no change.
  - Holding a button produces exactly one step. There is no auto-repeat.
- Mute is synchronized but not debounced. It does not alter the gain register.
- Datapath is a 2-stage pipeline with no backpressure:
  - Stage 1, on in_valid: product = in_data × {0,gain}, signed, DATA_BITS+GAIN_BITS+1 bits wide. Stage 1 uses the gain register value present in that cycle.
  - Stage 2: arithmetic right shift by GAIN_FRAC (truncation toward −∞). Then saturate to the signed DATA_BITS range, 0x7FFFFF / 0x800000 for defaults. If synced mute = 1 in this cycle, out_data = 0.
  - out_valid follows the in_valid pipeline. out_data holds its value when out_valid = 0.

## Timing
- Reset values:
  - gain = GAIN_RESET
  - out_valid = 0, out_data = 0
  - all synchronizer flops, debounced states, counters, press pulses and pipeline valids = 0
- Reset mid-stream discards in-flight samples. out_valid = 0 on the cycle after the rst-low edge.
- Datapath latency: in_valid at edge N gives out_valid at edge N+2. Back-to-back valids are supported at full rate.
- Button latency, with the button held stable high from edge 0:
  - debounced state flips at edge DEBOUNCE_CYCLES+2
  - press pulse at edge DEBOUNCE_CYCLES+3
  - gain changes at edge DEBOUNCE_CYCLES+4
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse. Release is debounced identically.
- Mute latency: 2 synchronizer cycles. It applies to whatever sample is in stage 2 once synced.

## Structure
- Shared audio package:
  - sample typedef (signed DATA_BITS)
  - gain typedef
  - GAIN_UNITY = 1 << GAIN_FRAC
  - SAMPLE_MAX / SAMPLE_MIN constants
- Sub-module `debounce`, parameterized by DEBOUNCE_CYCLES, containing synchronizer, counter, debounced level and rise pulse. Instantiated twice.
- Mute uses a bare 2-flop synchronizer inside volume_ctrl.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- Reset and unity gain:
  - rst low for 2 cycles, release → gain=128, out_valid=0.
  - in_data=0x123456 at edge N → out_valid and out_data=0x123456 at edge N+2.
  - Back-to-back samples 0x000001, 0xFFFFFF → 0x000001, 0xFFFFFF on consecutive cycles.
- Debounce:
  - btn_up held 40 cycles → gain 128→136 exactly once, at edge 8.
  - 2-cycle btn_up glitch → gain unchanged.
  - btn_up and btn_down pressed on the same edge → gain unchanged.
- Gain limits:
  - 16 down presses from 128 → gain 0, and a 17th press stays 0; in_data 0x400000 → out 0.
  - 16 up presses from 128 → 248 then 255; a further press stays 255.
- Saturation at gain=255:
  - in 0x400000 → 0x7F8000
  - in 0x600000 → 0x7FFFFF
  - in 0xA00000 → 0x800000
  - in 0xFFFFFF → 0xFFFFFE (floor)
- Mute:
  - mute high → out_data=0 while out_valid keeps strobing; gain unchanged.
  - mute low → scaling resumes 2 cycles after synchronization.
- Reset mid-operation: at gain=200 with a sample in flight, assert rst → no out_valid for the flushed sample, gain=128.
